// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank_driver
//  Description : Controlling end of a bank of JK flip-flops. Accepts a target
//                word over valid/ready and turns it into per-bit J/K
//                excitation from the bank's fed-back Q. Drives one clock of
//                excitation, checks the result, retries a bounded number of
//                times, and finishes each request with a done or err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Retry counter must hold 0..MAX_RETRY; keep at least one bit so the
    // MAX_RETRY=0 case still has a legal (constant-zero) counter.
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RETRY_W-1:0] c_MAX_RETRY = RETRY_W'(MAX_RETRY);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DRIVE = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    logic [2:0]         r_state;
    logic [WIDTH-1:0]   r_tgt;
    logic [RETRY_W-1:0] r_retry;
    logic [WIDTH-1:0]   r_j;
    logic [WIDTH-1:0]   r_k;
    logic               r_done;
    logic               r_err;

    logic [WIDTH-1:0]   w_src_tgt;
    logic [WIDTH-1:0]   w_j;
    logic [WIDTH-1:0]   w_k;
    logic               w_accept;
    logic               w_match;

    // In IDLE the excitation is built from the incoming word (it is latched
    // on the same edge); on a retry it is rebuilt from the held target.
    assign w_src_tgt = (r_state == c_ST_IDLE) ? tgt_data : r_tgt;

    // Per-bit excitation: set on 0->1, reset on 1->0, hold otherwise.
    // J and K are never both high, so the bank is never asked to toggle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_excite
            assign w_j[gi] =  w_src_tgt[gi] & ~q_fb[gi];
            assign w_k[gi] = ~w_src_tgt[gi] &  q_fb[gi];
        end
    endgenerate

    // Ready is gated by rst so a request presented during reset is not taken.
    assign tgt_ready = (r_state == c_ST_IDLE) & ~rst;
    assign w_accept  = tgt_valid & tgt_ready;
    assign w_match   = (q_fb == r_tgt);

    assign busy  = (r_state != c_ST_IDLE);
    assign j_out = r_j;
    assign k_out = r_k;
    assign done  = r_done;
    assign err   = r_err;

    // Request sequencer: accept, drive one cycle, check, retry or finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_tgt   <= '0;
            r_retry <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_tgt   <= tgt_data;
                        r_retry <= '0;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= c_ST_DRIVE;
                    end else begin
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                c_ST_DRIVE: begin
                    // Excitation is a single-cycle pulse; the bank has
                    // sampled it at this edge.
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= c_ST_CHECK;
                end
                c_ST_CHECK: begin
                    if (w_match) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else if (r_retry != c_MAX_RETRY) begin
                        r_retry <= r_retry + 1'b1;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= c_ST_DRIVE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_ERR;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_ERR: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_bank_driver
//  Description : Self-checking bench for jk_bank_driver driving a behavioural
//                JK flip-flop bank, with a stuck-at mask on the feedback path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

    localparam int WIDTH     = 4;
    localparam int MAX_RETRY = 3;

    logic             clk;
    logic             rst;
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             err;

    // Behavioural JK bank plus a preset port and a feedback stuck-at-0 mask.
    logic [WIDTH-1:0] r_bank_q;
    logic             bank_load;
    logic [WIDTH-1:0] bank_load_val;
    logic [WIDTH-1:0] stuck0_mask;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [WIDTH-1:0] q_init;
        logic [WIDTH-1:0] tgt;
        logic [WIDTH-1:0] exp_j;
        logic [WIDTH-1:0] exp_k;
    } vec_t;

    vec_t vecs[5];

    jk_bank_driver #(
        .WIDTH     (WIDTH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (tgt_ready),
        .q_fb      (q_fb),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK bank: hold, reset, set, toggle; not reset by rst.
    always @(posedge clk) begin
        if (bank_load) begin
            r_bank_q <= bank_load_val;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                case ({j_out[b], k_out[b]})
                    2'b10:   r_bank_q[b] <= 1'b1;
                    2'b01:   r_bank_q[b] <= 1'b0;
                    2'b11:   r_bank_q[b] <= ~r_bank_q[b];
                    default: r_bank_q[b] <= r_bank_q[b];
                endcase
            end
        end
    end

    assign q_fb = r_bank_q & ~stuck0_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [WIDTH-1:0] v);
        bank_load     = 1'b1;
        bank_load_val = v;
        step();
        bank_load     = 1'b0;
    endtask

    // Present one request for one edge; the caller is in IDLE.
    task automatic request(input logic [WIDTH-1:0] d);
        tgt_valid = 1'b1;
        tgt_data  = d;
        chk("ready_before_accept", {31'd0, tgt_ready}, 32'd1);
        step();
        tgt_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        tgt_valid     = 1'b1;
        tgt_data      = 4'b1111;
        bank_load     = 1'b1;
        bank_load_val = '0;
        stuck0_mask   = '0;

        vecs[0] = '{q_init: 4'b0000, tgt: 4'b1010, exp_j: 4'b1010, exp_k: 4'b0000};
        vecs[1] = '{q_init: 4'b1100, tgt: 4'b0110, exp_j: 4'b0010, exp_k: 4'b1000};
        vecs[2] = '{q_init: 4'b0101, tgt: 4'b0101, exp_j: 4'b0000, exp_k: 4'b0000};
        vecs[3] = '{q_init: 4'b1111, tgt: 4'b0000, exp_j: 4'b0000, exp_k: 4'b1111};
        vecs[4] = '{q_init: 4'b0011, tgt: 4'b1100, exp_j: 4'b1100, exp_k: 4'b0011};

        // Reset with tgt_valid high: nothing accepted, all outputs quiet.
        step();
        step();
        chk("rst_ready", {31'd0, tgt_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_j",     {28'd0, j_out},     32'd0);
        chk("rst_k",     {28'd0, k_out},     32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_err",   {31'd0, err},       32'd0);
        rst       = 1'b0;
        tgt_valid = 1'b0;
        bank_load = 1'b0;
        step();

        // Table-driven single-attempt requests.
        foreach (vecs[i]) begin
            load_bank(vecs[i].q_init);
            request(vecs[i].tgt);
            // after E0: DRIVE
            chk("vec_j_drive", {28'd0, j_out}, {28'd0, vecs[i].exp_j});
            chk("vec_k_drive", {28'd0, k_out}, {28'd0, vecs[i].exp_k});
            chk("vec_busy",    {31'd0, busy},  32'd1);
            chk("vec_ready_busy", {31'd0, tgt_ready}, 32'd0);
            step(); // after E1: CHECK
            chk("vec_j_check", {28'd0, j_out}, 32'd0);
            chk("vec_k_check", {28'd0, k_out}, 32'd0);
            chk("vec_done_early", {31'd0, done}, 32'd0);
            step(); // after E2: DONE
            chk("vec_done", {31'd0, done}, 32'd1);
            chk("vec_err",  {31'd0, err},  32'd0);
            chk("vec_ready_done", {31'd0, tgt_ready}, 32'd0);
            chk("vec_q", {28'd0, q_fb}, {28'd0, vecs[i].tgt});
            step(); // after E3: IDLE
            chk("vec_done_pulse", {31'd0, done}, 32'd0);
            chk("vec_ready_back", {31'd0, tgt_ready}, 32'd1);
        end

        // Bit 0 stuck at 0 for every attempt: four drives, then err.
        load_bank(4'b0000);
        stuck0_mask = 4'b0001;
        request(4'b0001);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            chk("stuck_j_drive", {28'd0, j_out}, 32'd1);
            chk("stuck_k_drive", {28'd0, k_out}, 32'd0);
            step();
            chk("stuck_j_check", {28'd0, j_out}, 32'd0);
            chk("stuck_no_done", {31'd0, done},  32'd0);
            chk("stuck_no_err",  {31'd0, err},   32'd0);
            step();
        end
        chk("stuck_err",     {31'd0, err},  32'd1);
        chk("stuck_done",    {31'd0, done}, 32'd0);
        chk("stuck_j_err",   {28'd0, j_out}, 32'd0);
        step();
        chk("stuck_err_pulse", {31'd0, err}, 32'd0);
        chk("stuck_ready",     {31'd0, tgt_ready}, 32'd1);
        stuck0_mask = '0;

        // Bit 0 stuck only for the first check: done after one retry.
        load_bank(4'b0000);
        stuck0_mask = 4'b0001;
        request(4'b0001);
        step(); // E1
        step(); // E2: first check fails, retry drive loaded
        stuck0_mask = '0;
        chk("retry1_j", {28'd0, j_out}, 32'd1);
        chk("retry1_no_done", {31'd0, done}, 32'd0);
        chk("retry1_busy", {31'd0, busy}, 32'd1);
        step(); // E3
        chk("retry1_no_done_e3", {31'd0, done}, 32'd0);
        step(); // E4
        chk("retry1_done", {31'd0, done}, 32'd1);
        chk("retry1_q", {28'd0, q_fb}, 32'd1);
        step();

        // tgt_valid held with changing data while busy: only first request.
        load_bank(4'b0000);
        tgt_valid = 1'b1;
        tgt_data  = 4'b1001;
        step(); // E0 accept 1001
        tgt_data  = 4'b0110;
        chk("hold_j", {28'd0, j_out}, 32'h9);
        step(); // E1
        chk("hold_ready_e1", {31'd0, tgt_ready}, 32'd0);
        step(); // E2
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_q", {28'd0, q_fb}, 32'h9);
        step(); // E3: back in IDLE, valid still high
        chk("hold_ready_e3", {31'd0, tgt_ready}, 32'd1);
        step(); // E4: second accept of 0110 against Q=1001
        tgt_valid = 1'b0;
        chk("hold2_j", {28'd0, j_out}, 32'h6);
        chk("hold2_k", {28'd0, k_out}, 32'h9);
        step();
        step();
        chk("hold2_done", {31'd0, done}, 32'd1);
        chk("hold2_q", {28'd0, q_fb}, 32'h6);
        step();

        // Reset asserted in the CHECK cycle: request abandoned.
        load_bank(4'b0000);
        request(4'b1111);
        step(); // now CHECK
        rst = 1'b1;
        chk("rstmid_ready", {31'd0, tgt_ready}, 32'd0);
        step();
        chk("rstmid_busy", {31'd0, busy},  32'd0);
        chk("rstmid_done", {31'd0, done},  32'd0);
        chk("rstmid_err",  {31'd0, err},   32'd0);
        chk("rstmid_j",    {28'd0, j_out}, 32'd0);
        chk("rstmid_k",    {28'd0, k_out}, 32'd0);
        chk("rstmid_q",    {28'd0, q_fb},  32'hf);
        rst = 1'b0;
        step();
        chk("rstmid_no_done", {31'd0, done}, 32'd0);
        chk("rstmid_ready_after", {31'd0, tgt_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
